// File: rtl/imi_capture.sv
// imi_capture: decimated I/Q snapshot buffer with a registered CPU read port.
// Optional pre-trigger ring capture is enabled by defining IMI_CAPTURE_PRETRIG_EN.
module imi_capture #(
    parameter int WIDTH   = 14,
    parameter int ADDR_W  = 10,
    parameter int DECIM_W = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic signed [WIDTH-1:0]   i_in,
    input  logic signed [WIDTH-1:0]   q_in,
    input  logic                      we,
    input  logic                      trig,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [ADDR_W:0]           len,
    input  logic [ADDR_W-1:0]         pre_len,
    input  logic [DECIM_W-1:0]        decim,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic [2*WIDTH-1:0]        rd_data,
    output logic [ADDR_W-1:0]         start_addr,
    output logic [1:0]                state,
    output logic [ADDR_W:0]           count,
    output logic                      done_irq
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } st_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    st_t                st_q, st_nxt;
    logic [ADDR_W:0]    cnt_q, cnt_nxt;
    logic [ADDR_W:0]    len_q, len_nxt;
    logic [ADDR_W:0]    len_sat;
    logic [ADDR_W:0]    pre_eff;
    logic [ADDR_W-1:0]  wa_q, wa_nxt;
    logic [ADDR_W-1:0]  sa_q, sa_nxt;
    logic [DECIM_W-1:0] dc_q, dc_nxt;
    logic [DECIM_W-1:0] dec_q, dec_nxt;
    logic               irq_q, irq_nxt;
    logic               wr_en;
    logic               trig_ok;
    logic [2*WIDTH-1:0] rd_q;
    logic [2*WIDTH-1:0] ram [2**ADDR_W];

    assign len_sat = (len == '0 || len > DEPTH) ? DEPTH : len;

`ifdef IMI_CAPTURE_PRETRIG_EN
    logic [ADDR_W:0] fill_q, fill_nxt;

    // Pre-trigger depth, clamped so at least one post-trigger sample remains
    always_comb begin
        pre_eff = {1'b0, pre_len};
        if (pre_eff >= len_sat)
            pre_eff = len_sat - 1'b1;
    end

    assign trig_ok = (fill_q >= pre_eff);

    // Ring fill level accumulated while armed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            fill_q <= '0;
        else
            fill_q <= fill_nxt;
    end
`else
    logic unused_pre;
    assign unused_pre = ^pre_len;
    assign pre_eff    = '0;
    assign trig_ok    = 1'b1;
`endif

    // Next-state, write strobe and bookkeeping for the capture FSM
    always_comb begin
        st_nxt  = st_q;
        cnt_nxt = cnt_q;
        len_nxt = len_q;
        wa_nxt  = wa_q;
        sa_nxt  = sa_q;
        dc_nxt  = dc_q;
        dec_nxt = dec_q;
        irq_nxt = 1'b0;
        wr_en   = 1'b0;
`ifdef IMI_CAPTURE_PRETRIG_EN
        fill_nxt = fill_q;
`endif
        unique case (st_q)
            S_IDLE: begin
                if (!abort && arm) begin
                    st_nxt  = S_ARMED;
                    cnt_nxt = '0;
                    wa_nxt  = '0;
                    dc_nxt  = '0;
`ifdef IMI_CAPTURE_PRETRIG_EN
                    fill_nxt = '0;
`endif
                end
            end
            S_ARMED: begin
                if (abort) begin
                    st_nxt = S_IDLE;
                end else if (trig && trig_ok) begin
                    len_nxt = len_sat;
                    dec_nxt = decim;
                    dc_nxt  = '0;
                    cnt_nxt = pre_eff;
`ifdef IMI_CAPTURE_PRETRIG_EN
                    sa_nxt = wa_q - pre_eff[ADDR_W-1:0];
`endif
                    if (we) begin
                        wr_en   = 1'b1;
                        wa_nxt  = wa_q + 1'b1;
                        cnt_nxt = pre_eff + 1'b1;
                        if (decim != '0)
                            dc_nxt = DECIM_W'(1);
                    end
                    if (cnt_nxt >= len_sat) begin
                        st_nxt  = S_DONE;
                        irq_nxt = 1'b1;
                    end else begin
                        st_nxt = S_CAPTURE;
                    end
                end
`ifdef IMI_CAPTURE_PRETRIG_EN
                else if (we) begin
                    dc_nxt = (dc_q >= decim) ? '0 : dc_q + 1'b1;
                    if (dc_q == '0) begin
                        wr_en  = 1'b1;
                        wa_nxt = wa_q + 1'b1;
                        if (fill_q != DEPTH)
                            fill_nxt = fill_q + 1'b1;
                    end
                end
`endif
            end
            S_CAPTURE: begin
                if (abort) begin
                    st_nxt = S_IDLE;
                end else if (we) begin
                    dc_nxt = (dc_q >= dec_q) ? '0 : dc_q + 1'b1;
                    if (dc_q == '0) begin
                        wr_en   = 1'b1;
                        wa_nxt  = wa_q + 1'b1;
                        cnt_nxt = cnt_q + 1'b1;
                        if (cnt_nxt >= len_q) begin
                            st_nxt  = S_DONE;
                            irq_nxt = 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    st_nxt = S_IDLE;
                end else if (arm) begin
                    st_nxt  = S_ARMED;
                    cnt_nxt = '0;
                    wa_nxt  = '0;
                    dc_nxt  = '0;
`ifdef IMI_CAPTURE_PRETRIG_EN
                    fill_nxt = '0;
`endif
                end
            end
            default: st_nxt = S_IDLE;
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q  <= S_IDLE;
            cnt_q <= '0;
            len_q <= DEPTH;
            wa_q  <= '0;
            sa_q  <= '0;
            dc_q  <= '0;
            dec_q <= '0;
            irq_q <= 1'b0;
        end else begin
            st_q  <= st_nxt;
            cnt_q <= cnt_nxt;
            len_q <= len_nxt;
            wa_q  <= wa_nxt;
            sa_q  <= sa_nxt;
            dc_q  <= dc_nxt;
            dec_q <= dec_nxt;
            irq_q <= irq_nxt;
        end
    end

    // Sample RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en)
            ram[wa_q] <= {q_in, i_in};
    end

    // Registered read port; same-address write returns old data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            rd_q <= '0;
        else
            rd_q <= ram[rd_addr];
    end

    assign rd_data    = rd_q;
    assign start_addr = sa_q;
    assign state      = st_q;
    assign count      = cnt_q;
    assign done_irq   = irq_q;

endmodule

// File: tb/tb_imi_capture.sv
// tb_imi_capture: directed vectors for imi_capture (default build).
// Depth is reduced to 16 words so full-depth bursts stay short.
module tb_imi_capture;

    localparam int W  = 14;
    localparam int AW = 4;
    localparam int DW = 8;

    logic                clk = 1'b0;
    logic                resetn = 1'b0;
    logic signed [W-1:0] i_in = '0;
    logic signed [W-1:0] q_in = '0;
    logic                we = 1'b0;
    logic                trig = 1'b0;
    logic                arm = 1'b0;
    logic                abort = 1'b0;
    logic [AW:0]         len = '0;
    logic [AW-1:0]       pre_len = '0;
    logic [DW-1:0]       decim = '0;
    logic [AW-1:0]       rd_addr = '0;
    logic [2*W-1:0]      rd_data;
    logic [AW-1:0]       start_addr;
    logic [1:0]          state;
    logic [AW:0]         count;
    logic                done_irq;

    int n_vec = 0;
    int n_err = 0;
    int irq_cnt = 0;

    imi_capture #(
        .WIDTH   (W),
        .ADDR_W  (AW),
        .DECIM_W (DW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_in       (i_in),
        .q_in       (q_in),
        .we         (we),
        .trig       (trig),
        .arm        (arm),
        .abort      (abort),
        .len        (len),
        .pre_len    (pre_len),
        .decim      (decim),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .start_addr (start_addr),
        .state      (state),
        .count      (count),
        .done_irq   (done_irq)
    );

    always #5 clk = ~clk;

    // Count cycles with the completion pulse high
    always @(negedge clk)
        if (done_irq) irq_cnt++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word(input int q, input int i);
        logic [W-1:0] qq;
        logic [W-1:0] ii;
        qq = W'(q);
        ii = W'(i);
        return {4'b0, qq, ii};
    endfunction

    initial begin
        repeat (2) tick();
        check("rst_state", 32'(state), 0);
        check("rst_count", 32'(count), 0);
        check("rst_start", 32'(start_addr), 0);
        check("rst_irq", 32'(done_irq), 0);
        check("rst_rd", 32'(rd_data), 0);
        resetn = 1'b1;
        tick();

        // Basic burst: len=4, decim=0
        len = 5'd4; decim = '0;
        trig = 1'b1;
        tick();
        check("idle_trig_ignored", 32'(state), 0);
        trig = 1'b0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t1_armed", 32'(state), 1);
        we = 1'b1; trig = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            i_in = W'(k);
            q_in = W'(-k);
            tick();
            trig = 1'b0;
            check("t1_count", 32'(count), 32'(k));
            check("t1_state", 32'(state), (k < 4) ? 2 : 3);
        end
        check("t1_irq_hi", 32'(done_irq), 1);
        we = 1'b0;
        tick();
        check("t1_irq_lo", 32'(done_irq), 0);
        check("t1_irq_cnt", 32'(irq_cnt), 1);
        for (int k = 0; k < 4; k++) begin
            rd_addr = AW'(k);
            tick();
            check("t1_ram", 32'(rd_data), word(-(k + 1), k + 1));
        end

        // Decimation: keep 1 of 3, trigger at ramp sample 5
        decim = 8'd2; len = 5'd3;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        we = 1'b1;
        for (int s = 0; s <= 20; s++) begin
            i_in = W'(s);
            q_in = W'(s + 100);
            trig = (s == 5);
            tick();
        end
        trig = 1'b0; we = 1'b0;
        check("t2_state", 32'(state), 3);
        check("t2_count", 32'(count), 3);
        for (int k = 0; k < 3; k++) begin
            rd_addr = AW'(k);
            tick();
            check("t2_ram", 32'(rd_data), word(105 + 3 * k, 5 + 3 * k));
        end
        check("t2_irq_cnt", 32'(irq_cnt), 2);

        // Qualifier toggling: done 3 cycles after trigger
        decim = '0; len = 5'd2;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; we = 1'b1; i_in = 14'd7; q_in = '0;
        tick();
        trig = 1'b0;
        check("t3_c1_state", 32'(state), 2);
        check("t3_c1_count", 32'(count), 1);
        we = 1'b0; i_in = 14'd8;
        tick();
        check("t3_c2_state", 32'(state), 2);
        we = 1'b1; i_in = 14'd9;
        tick();
        we = 1'b0;
        check("t3_c3_state", 32'(state), 3);
        check("t3_count", 32'(count), 2);
        rd_addr = 4'd0;
        tick();
        check("t3_ram0", 32'(rd_data), word(0, 7));
        rd_addr = 4'd1;
        tick();
        check("t3_ram1", 32'(rd_data), word(0, 9));
        check("t3_irq_cnt", 32'(irq_cnt), 3);

        // Abort at count=2 of len=8
        len = 5'd8;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; we = 1'b1; i_in = 14'd20;
        tick();
        trig = 1'b0; i_in = 14'd21;
        tick();
        check("t4_pre_count", 32'(count), 2);
        abort = 1'b1; i_in = 14'd22;
        tick();
        abort = 1'b0; we = 1'b0;
        check("t4_state", 32'(state), 0);
        check("t4_count", 32'(count), 2);
        check("t4_irq", 32'(done_irq), 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        check("t4_trig_state", 32'(state), 0);
        check("t4_trig_count", 32'(count), 2);
        check("t4_irq_cnt", 32'(irq_cnt), 3);

        // Full depth via len=0
        len = '0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_arm_count", 32'(count), 0);
        trig = 1'b1; we = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_in = W'(40 + k);
            q_in = W'(k);
            tick();
            trig = 1'b0;
            if (k == 14) check("t5_mid_state", 32'(state), 2);
        end
        we = 1'b0;
        check("t5_state", 32'(state), 3);
        check("t5_count", 32'(count), 16);
        rd_addr = 4'd15;
        tick();
        check("t5_ram15", 32'(rd_data), word(15, 55));
        rd_addr = 4'd0;
        tick();
        check("t5_ram0", 32'(rd_data), word(0, 40));
        check("t5_irq_cnt", 32'(irq_cnt), 4);

        // len above depth saturates to depth
        len = 5'd20;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b1; we = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_in = W'(60 + k);
            q_in = 14'd1;
            tick();
            trig = 1'b0;
            if (k == 14) check("t6_mid_state", 32'(state), 2);
        end
        we = 1'b0;
        check("t6_state", 32'(state), 3);
        check("t6_count", 32'(count), 16);

        // Same-address read during write returns old word
        arm = 1'b1;
        tick();
        arm = 1'b0;
        rd_addr = 4'd0;
        trig = 1'b1; we = 1'b1; i_in = 14'd99; q_in = '0;
        tick();
        trig = 1'b0; we = 1'b0;
        check("t7_rd_old", 32'(rd_data), word(1, 60));
        tick();
        check("t7_rd_new", 32'(rd_data), word(0, 99));
        check("t7_state", 32'(state), 2);

        // Reset mid-capture
        resetn = 1'b0;
        #1;
        check("t8_state", 32'(state), 0);
        check("t8_irq", 32'(done_irq), 0);
        check("t8_count", 32'(count), 0);
        tick();
        resetn = 1'b1;
        tick();
        check("t8_irq_cnt", 32'(irq_cnt), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
